// File: rtl/fft_stage_feeder.sv
// Frame buffer feeding one radix-2 FFT stage: fills N_SAMPLES complex words,
// then presents the N_SAMPLES/2 butterfly operand pairs of stage STAGE in order.
module fft_stage_feeder #(
    parameter int n         = 32,
    parameter int d         = 16,
    parameter int N_SAMPLES = 8,
    parameter int STAGE     = 0,
    localparam int LOGN     = $clog2(N_SAMPLES),
    localparam int TW_W     = (LOGN - 1 < 1) ? 1 : LOGN - 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            recv_val,
    output logic            recv_rdy,
    input  logic [n-1:0]    recv_r,
    input  logic [n-1:0]    recv_c,
    output logic            send_val,
    input  logic            send_rdy,
    output logic [n-1:0]    ar,
    output logic [n-1:0]    ac,
    output logic [n-1:0]    br,
    output logic [n-1:0]    bc,
    output logic [TW_W-1:0] tw_idx
);

    localparam int              SPAN     = 1 << STAGE;
    localparam int              TW_SHIFT = LOGN - 1 - STAGE;
    localparam logic [LOGN-1:0] J_MASK   = LOGN'(SPAN - 1);
    localparam logic [LOGN-1:0] SPAN_BIT = LOGN'(SPAN);
    localparam logic [LOGN-1:0] W_LAST   = LOGN'(N_SAMPLES - 1);
    localparam logic [LOGN-1:0] P_LAST   = LOGN'(N_SAMPLES / 2 - 1);

    // d only documents the fixed-point format; data passes through untouched.
    if (d < 0 || d > n || N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0 ||
        STAGE < 0 || STAGE >= LOGN) begin : g_bad_params
        $error("fft_stage_feeder: illegal parameter combination");
    end

    typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} state_t;

    state_t          state;
    logic [LOGN-1:0] w;
    logic [LOGN-1:0] p;
    logic [n-1:0]    mem_r [N_SAMPLES];
    logic [n-1:0]    mem_c [N_SAMPLES];
    logic [LOGN-1:0] j_idx;
    logic [LOGN-1:0] a_idx;
    logic [LOGN-1:0] b_idx;
    logic [TW_W-1:0] tw_full;

    // Handshake: a word moves on any rising edge where val and rdy are both 1;
    // the source holds val/data until then, and rdy never depends on val.
    assign recv_rdy = (state == FILL) && reset;
    assign send_val = (state == ISSUE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            w     <= '0;
            p     <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (recv_val) begin
                        if (w == W_LAST) begin
                            w     <= '0;
                            state <= ISSUE;
                        end else begin
                            w <= w + LOGN'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (send_rdy) begin
                        if (p == P_LAST) begin
                            p     <= '0;
                            state <= FILL;
                        end else begin
                            p <= p + LOGN'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // The frame buffer is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (recv_val && recv_rdy) begin
            mem_r[w] <= recv_r;
            mem_c[w] <= recv_c;
        end
    end

    // p = g*S + j maps to a = 2*S*g + j, b = a + S, twiddle = j * N/(2S).
    always_comb begin
        j_idx   = p & J_MASK;
        a_idx   = ((p >> STAGE) << (STAGE + 1)) | j_idx;
        b_idx   = a_idx | SPAN_BIT;
        tw_full = TW_W'(j_idx << TW_SHIFT);
    end

    always_comb begin
        ar     = '0;
        ac     = '0;
        br     = '0;
        bc     = '0;
        tw_idx = '0;
        if (send_val) begin
            ar     = mem_r[a_idx];
            ac     = mem_c[a_idx];
            br     = mem_r[b_idx];
            bc     = mem_c[b_idx];
            tw_idx = tw_full;
        end
    end

endmodule

// File: tb/tb_fft_stage_feeder.sv
// Bench for fft_stage_feeder: three instances (STAGE 0,1,2, N=8) share stimulus;
// a frame-level model predicts operand pairs and handshake levels per cycle.
module tb_fft_stage_feeder;

    localparam int NW   = 32;
    localparam int NS   = 8;
    localparam int NST  = 3;
    localparam int TW_W = 2;
    localparam int W    = 4 * NW + TW_W;

    logic            clk;
    logic            reset;
    logic            recv_val;
    logic [NW-1:0]   recv_r;
    logic [NW-1:0]   recv_c;
    logic            send_rdy;
    logic            recv_rdy_o [NST];
    logic            send_val_o [NST];
    logic [NW-1:0]   ar_o [NST];
    logic [NW-1:0]   ac_o [NST];
    logic [NW-1:0]   br_o [NST];
    logic [NW-1:0]   bc_o [NST];
    logic [TW_W-1:0] tw_o [NST];

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 2;

    logic [W-1:0]      exp_q [NST][$];
    logic [2*NW-1:0]   frame_q[$];
    bit                filling = 1'b1;
    int                pairs_left = 0;

    for (genvar gi = 0; gi < NST; gi++) begin : g_dut
        fft_stage_feeder #(.n(NW), .d(16), .N_SAMPLES(NS), .STAGE(gi)) dut (
            .clk      (clk),
            .reset    (reset),
            .recv_val (recv_val),
            .recv_rdy (recv_rdy_o[gi]),
            .recv_r   (recv_r),
            .recv_c   (recv_c),
            .send_val (send_val_o[gi]),
            .send_rdy (send_rdy),
            .ar       (ar_o[gi]),
            .ac       (ac_o[gi]),
            .br       (br_o[gi]),
            .bc       (bc_o[gi]),
            .tw_idx   (tw_o[gi])
        );
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [NW-1:0] a_r, input logic [NW-1:0] a_c,
                                          input logic [NW-1:0] b_r, input logic [NW-1:0] b_c,
                                          input logic [TW_W-1:0] t);
        return {a_r, a_c, b_r, b_c, t};
    endfunction

    // Every stage's pair list, straight from the radix-2 butterfly definition.
    task automatic build_expected();
        logic [2*NW-1:0] sa;
        logic [2*NW-1:0] sb;
        int span, ai, bi, t;
        for (int s = 0; s < NST; s++) begin
            span = 1 << s;
            for (int g = 0; g < NS / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    ai = 2 * span * g + j;
                    bi = ai + span;
                    t  = j * (NS / (2 * span));
                    sa = frame_q[ai];
                    sb = frame_q[bi];
                    exp_q[s].push_back(pack(sa[2*NW-1:NW], sa[NW-1:0], sb[2*NW-1:NW], sb[NW-1:0],
                                            TW_W'(t)));
                end
            end
        end
    endtask

    // scoreboard / monitor: sample at negedge, then advance the model to the next edge
    always @(negedge clk) begin
        if (!reset) begin
            for (int s = 0; s < NST; s++) begin
                check("reset_recv_rdy", W'(recv_rdy_o[s]), '0);
                check("reset_send_val", W'(send_val_o[s]), '0);
                check("reset_outputs", pack(ar_o[s], ac_o[s], br_o[s], bc_o[s], tw_o[s]), '0);
                exp_q[s].delete();
            end
            frame_q.delete();
            filling    = 1'b1;
            pairs_left = 0;
        end else begin
            for (int s = 0; s < NST; s++) begin
                check("recv_rdy", W'(recv_rdy_o[s]), W'(filling));
                check("send_val", W'(send_val_o[s]), W'(!filling));
                if (send_val_o[s]) begin
                    if (exp_q[s].size() == 0) begin
                        check("unexpected_pair", pack(ar_o[s], ac_o[s], br_o[s], bc_o[s], tw_o[s]), 'x);
                    end else begin
                        check("pair", pack(ar_o[s], ac_o[s], br_o[s], bc_o[s], tw_o[s]), exp_q[s][0]);
                        if (send_rdy) void'(exp_q[s].pop_front());
                    end
                end else begin
                    check("idle_outputs", pack(ar_o[s], ac_o[s], br_o[s], bc_o[s], tw_o[s]), '0);
                end
            end
            if (filling) begin
                if (recv_val) begin
                    frame_q.push_back({recv_r, recv_c});
                    if (frame_q.size() == NS) begin
                        build_expected();
                        frame_q.delete();
                        filling    = 1'b0;
                        pairs_left = NS / 2;
                    end
                end
            end else if (send_rdy) begin
                pairs_left--;
                if (pairs_left == 0) filling = 1'b1;
            end
        end
    end

    // downstream ready driver: 0 = always ready, 1 = random, 2 = left to main sequence
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) send_rdy = 1'b1;
        else if (rdy_mode == 1) send_rdy = ($urandom_range(0, 3) != 0);
    end

    // driver tasks
    // mode 0: real k+1, imag 0; mode 1: base+k / base+k+0x80; mode 2: random.
    // gap 0: valid always; 1: valid every other cycle; 2: random valid.
    task automatic send_samples(input int count, input int mode, input int base, input int gap);
        int  k = 0;
        int  cyc = 0;
        bit  v;
        bit  acc;
        while (k < count && cyc < 4000) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'(($urandom_range(0, 1)));
            recv_val = v;
            case (mode)
                0: begin recv_r = NW'(k % NS + 1); recv_c = '0; end
                1: begin recv_r = NW'(base + k); recv_c = NW'(base + k + 'h80); end
                default: begin recv_r = $urandom; recv_c = $urandom; end
            endcase
            @(negedge clk);
            acc = v && recv_rdy_o[0];
            @(posedge clk);
            #1;
            if (acc) k++;
            cyc++;
        end
        recv_val = 1'b0;
        if (k < count) check("send_samples_timeout", W'(k), W'(count));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("async_reset_send_val", W'(send_val_o[1]), '0);
        check("async_reset_recv_rdy", W'(recv_rdy_o[1]), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_reset_recv_rdy", W'(recv_rdy_o[1]), W'(1));
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0 || !filling)
               && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_done", W'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), '0);
    endtask

    initial begin
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_r   = '0;
        recv_c   = '0;
        send_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        rdy_mode = 0;

        // canonical frame k+1 / 0 with downstream always ready
        send_samples(NS, 0, 0, 0);
        drain();

        // stall on the second pair, with input pulses that must be ignored
        rdy_mode = 2;
        send_rdy = 1'b1;
        send_samples(NS, 1, 'h200, 0);
        @(posedge clk);
        #1;
        send_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            recv_val = (i % 2 == 0);
            recv_r   = $urandom;
            recv_c   = $urandom;
            @(posedge clk);
            #1;
        end
        recv_val = 1'b0;
        rdy_mode = 0;
        send_rdy = 1'b1;
        drain();

        // sparse input valid
        send_samples(NS, 1, 'h300, 1);
        drain();

        // reset after 5 samples, then a fresh frame of 0x10.. values
        send_samples(5, 1, 'h500, 0);
        apply_reset();
        send_samples(NS, 1, 'h10, 0);
        drain();

        // reset in the middle of issuing pairs
        send_samples(NS, 2, 0, 0);
        @(posedge clk);
        #1;
        apply_reset();
        send_samples(NS, 1, 'h40, 0);
        drain();

        // back-to-back frames with both valids held high
        send_samples(3 * NS, 1, 'h1000, 0);
        drain();

        // random data, random input valid, random downstream ready
        rdy_mode = 1;
        send_samples(20 * NS, 2, 0, 2);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
